// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, start, 8 data bits, odd parity, stop, ACK, timeout)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);
    localparam int MAX_CNT = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic          clk_prev_q, clk_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    sr_q, sr_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic          ack_bit_q, ack_bit_d;
    logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
    logic          done_q, done_d, ack_err_q, ack_err_d, tmo_q, tmo_d;
    logic          fe, counting;

    // Next-state logic: the inhibit delay and the edge timeout share one counter
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        bitcnt_d   = bitcnt_q;
        ack_bit_d  = ack_bit_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        done_d     = 1'b0;
        ack_err_d  = 1'b0;
        tmo_d      = 1'b0;
        clk_sync_d = {clk_sync_q[0], ps2_clk_in};
        dat_sync_d = {dat_sync_q[0], ps2_dat_in};
        clk_prev_d = clk_sync_q[1];
        fe         = clk_prev_q & ~clk_sync_q[1];
        counting   = state_q inside {START, SHIFT, ACK, WAIT_IDLE};
        if (counting) cnt_d = fe ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE: if (tx_valid) begin
                state_d  = INHIBIT;
                cnt_d    = '0;
                sr_d     = {~^tx_data, tx_data};
                clk_oe_d = 1'b1;
            end
            INHIBIT: if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                state_d  = START;
                cnt_d    = '0;
                dat_oe_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            START: begin
                state_d  = SHIFT;
                clk_oe_d = 1'b0;
                bitcnt_d = '0;
            end
            SHIFT: if (fe) begin
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == 4'd9) begin
                    dat_oe_d = 1'b0;
                    state_d  = ACK;
                end else begin
                    dat_oe_d = ~sr_q[0];
                    sr_d     = {1'b1, sr_q[8:1]};
                end
            end
            ACK: if (fe) begin
                ack_bit_d = dat_sync_q[1];
                state_d   = WAIT_IDLE;
            end
            WAIT_IDLE: if (clk_sync_q[1] & dat_sync_q[1]) begin
                state_d   = IDLE;
                done_d    = ~ack_bit_q;
                ack_err_d = ack_bit_q;
            end
            default: state_d = IDLE;
        endcase
        // A device edge in the limit cycle wins, as does a clean finish in WAIT_IDLE
        if (counting && !fe && cnt_q == CW'(TIMEOUT_CYCLES - 1) && state_d != IDLE) begin
            state_d  = IDLE;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            tmo_d    = 1'b1;
        end
    end

    // State and registered outputs; reset releases both lines immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            cnt_q      <= '0;
            sr_q       <= '0;
            bitcnt_q   <= '0;
            ack_bit_q  <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            bitcnt_q   <= bitcnt_d;
            ack_bit_q  <= ack_bit_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            tmo_q      <= tmo_d;
        end
    end

    assign tx_ready    = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_dat_oe  = dat_oe_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout_err = tmo_q;
endmodule
